// File: rtl/matrix_b_mvm.sv
// GF(2) matrix-vector multiply: sweeps the matrix_B ROM row by row and builds
// y = B*x, one parity bit per row, absorbing the ROM's 1-cycle read latency.
module matrix_b_mvm #(
   parameter int ADDR_W = 9,
   parameter int DAT_W  = 2100,
   parameter int N_ROWS = 500
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [DAT_W-1:0]  i_x_in,
   output logic [ADDR_W-1:0] o_rom_addr,
   input  logic [DAT_W-1:0]  i_rom_dout,
   output logic              o_busy,
   output logic              o_done,
   output logic [N_ROWS-1:0] o_y_out
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_ROWS - 1);

   state_t              r_state, w_next;
   logic [DAT_W-1:0]    r_x;
   logic [N_ROWS-1:0]   r_y;
   logic [ADDR_W-1:0]   r_addr, r_idx1, r_idx2;
   logic                r_v1, r_v2;
   logic                w_accept, w_par;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_next = S_RUN;
         S_RUN:   if (r_addr == LAST) w_next = S_DRAIN;
         S_DRAIN: if (r_v1 && r_idx1 == LAST) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_accept = (r_state == S_IDLE) && i_start;
      o_busy   = (r_state != S_IDLE);
      // Last row's bit landed on the previous edge and we are back in IDLE.
      o_done   = (r_state == S_IDLE) && r_v2 && (r_idx2 == LAST);
   end

   // Parity of the row arriving this cycle is written straight into y, so
   // row k is visible two cycles after its address was issued.
   assign w_par = ^(i_rom_dout & r_x);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_x    <= '0;
         r_y    <= '0;
         r_addr <= '0;
         r_v1   <= 1'b0;
         r_v2   <= 1'b0;
         r_idx1 <= '0;
         r_idx2 <= '0;
      end else begin
         if (w_accept) r_x <= i_x_in;
         r_addr <= (r_state == S_RUN && r_addr != LAST) ? r_addr + 1'b1 : '0;
         r_v1   <= (r_state == S_RUN);
         r_idx1 <= r_addr;
         r_v2   <= r_v1;
         r_idx2 <= r_idx1;
         if (w_accept)  r_y <= '0;
         else if (r_v1) r_y[r_idx1] <= w_par;
      end
   end

   assign o_rom_addr = r_addr;
   assign o_y_out    = r_y;

endmodule

// File: tb/tb_matrix_b_mvm.sv
// Randomized bench for matrix_b_mvm: behavioural ROM with 1-cycle latency and a
// bit-counting reference model for y = B*x over GF(2).
module tb_matrix_b_mvm;

   localparam int AW = 9;
   localparam int DW = 2100;
   localparam int N  = 500;

   logic          clk = 1'b0;
   logic          i_rst, i_start;
   logic [DW-1:0] i_x, rom_dout;
   logic [AW-1:0] o_rom_addr;
   logic          o_busy, o_done;
   logic [N-1:0]  o_y_out;

   logic [DW-1:0] rom [0:(1<<AW)-1];

   int n_cmp  = 0;
   int n_fail = 0;

   matrix_b_mvm #(.ADDR_W(AW), .DAT_W(DW), .N_ROWS(N)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_x_in(i_x),
      .o_rom_addr(o_rom_addr), .i_rom_dout(rom_dout), .o_busy(o_busy),
      .o_done(o_done), .o_y_out(o_y_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_dout <= rom[o_rom_addr];

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_vec();
      logic [DW-1:0] v;
      int unsigned   w;
      w = 0;
      for (int j = 0; j < DW; j++) begin
         if (j % 32 == 0) w = $urandom;
         v[j] = w[j % 32];
      end
      return v;
   endfunction

   task automatic fill_random();
      for (int i = 0; i < (1 << AW); i++) rom[i] = (i < N) ? rand_vec() : '0;
   endtask

   // y[i] = (number of j with B[i][j]=1 and x[j]=1) mod 2
   function automatic logic [N-1:0] ref_mvm(input logic [DW-1:0] x);
      logic [N-1:0] y;
      int           cnt;
      for (int i = 0; i < N; i++) begin
         cnt = 0;
         for (int j = 0; j < DW; j++) if (rom[i][j] && x[j]) cnt++;
         y[i] = (cnt % 2 == 1);
      end
      return y;
   endfunction

   task automatic do_run(input logic [DW-1:0] x, input logic [N-1:0] exp_y, input string tag);
      int cyc, busy_cnt, addr_bad;
      bit seen;
      @(negedge clk);
      i_start = 1'b1;
      i_x     = x;
      @(negedge clk);
      cyc = 1; busy_cnt = 0; addr_bad = 0; seen = 0;
      while (cyc < 700) begin
         if (o_busy) busy_cnt++;
         if (cyc <= N && o_rom_addr !== AW'(cyc - 1)) addr_bad++;
         if (o_done) begin
            seen = 1;
            break;
         end
         i_start = (cyc <= N) ? 1'($urandom) : 1'b0;
         i_x     = rand_vec();
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_done_seen"}, 512'(seen), 512'(1));
      chk({tag, "_latency"}, 512'(cyc), 512'(N + 2));
      chk({tag, "_busy_cycles"}, 512'(busy_cnt), 512'(N + 1));
      chk({tag, "_addr_seq_errs"}, 512'(addr_bad), 512'(0));
      chk({tag, "_y"}, 512'(o_y_out), 512'(exp_y));
      i_x = rand_vec();
      @(negedge clk);
      chk({tag, "_done_pulse"}, 512'(o_done), 512'(0));
      chk({tag, "_idle_busy"}, 512'(o_busy), 512'(0));
      chk({tag, "_y_hold"}, 512'(o_y_out), 512'(exp_y));
   endtask

   initial begin
      logic [DW-1:0] x, xa;
      logic [N-1:0]  ey;
      int            cyc, last, runs, dcnt;

      i_rst = 1'b1; i_start = 1'b0; i_x = '0;
      fill_random();

      // Reset held two cycles with random start/x
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         i_start = 1'($urandom);
         i_x     = rand_vec();
         @(negedge clk);
         chk("rst_busy", 512'(o_busy), 512'(0));
         chk("rst_done", 512'(o_done), 512'(0));
         chk("rst_addr", 512'(o_rom_addr), 512'(0));
         chk("rst_y", 512'(o_y_out), 512'(0));
      end
      i_rst = 1'b0; i_start = 1'b0;

      do_run('0, '0, "zero");

      x = '0; x[0] = 1'b1;
      for (int i = 0; i < N; i++) ey[i] = rom[i][0];
      do_run(x, ey, "onehot_lo");

      x = '0; x[DW-1] = 1'b1;
      for (int i = 0; i < N; i++) ey[i] = rom[i][DW-1];
      do_run(x, ey, "onehot_hi");

      for (int r = 0; r < 2; r++) begin
         x = rand_vec();
         do_run(x, ref_mvm(x), "random");
      end

      // Stub ROM: row i has exactly i ones
      for (int i = 0; i < N; i++) begin
         rom[i] = '0;
         for (int j = 0; j < i; j++) rom[i][j] = 1'b1;
      end
      for (int i = 0; i < N; i++) ey[i] = (i % 2 == 1);
      do_run('1, ey, "parity");

      // Continuous start, x changing every cycle
      fill_random();
      @(negedge clk);
      i_start = 1'b1;
      xa = rand_vec();
      i_x = xa;
      cyc = 0; last = 0; runs = 0;
      while (runs < 3 && cyc < 3 * 600) begin
         @(negedge clk);
         cyc++;
         if (o_done) begin
            chk("cont_y", 512'(o_y_out), 512'(ref_mvm(xa)));
            chk("cont_period", 512'(cyc - last), 512'(N + 2));
            last = cyc;
            runs++;
            xa = rand_vec();
            i_x = xa;
            if (runs == 3) i_start = 1'b0;
         end else begin
            i_x = rand_vec();
         end
      end
      chk("cont_runs", 512'(runs), 512'(3));
      i_start = 1'b0;
      repeat (3) @(negedge clk);

      // Mid-run reset, then rerun with the same x
      x = rand_vec();
      i_start = 1'b1; i_x = x;
      @(negedge clk);
      i_start = 1'b0;
      repeat (99) @(negedge clk);
      i_rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", 512'(o_busy), 512'(0));
      chk("midrst_done", 512'(o_done), 512'(0));
      chk("midrst_addr", 512'(o_rom_addr), 512'(0));
      chk("midrst_y", 512'(o_y_out), 512'(0));
      i_rst = 1'b0;
      dcnt = 0;
      repeat (600) begin
         @(negedge clk);
         if (o_done) dcnt++;
      end
      chk("midrst_no_done", 512'(dcnt), 512'(0));
      do_run(x, ref_mvm(x), "after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
